// File: rtl/s2p_pkg.sv
// Shared types and defaults for the serial-to-parallel converter.
package s2p_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int STAT_W         = 16;

  // Saturating add used by the statistics counters.
  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [1:0]        inc);
    logic [STAT_W:0] sum;
    sum = {1'b0, a} + {{(STAT_W-1){1'b0}}, inc};
    return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/s2p_fifo.sv
// Frame buffer for serial_to_parallel: power-of-two depth, wrapping
// pointers, occupancy counter one bit wider than the pointers.
// A push into a full buffer is accepted only when a pop happens on the same edge.
module s2p_fifo
  import s2p_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next pointer, storage and occupancy values.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  // Buffer state registers; storage is cleared so dout reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel converter: LSB-first framing FSM feeding an output FIFO.
// Optional build macro S2P_STATS_EN adds saturating frame_cnt / err_cnt outputs.
//
// state | meaning
// IDLE  | bit counter 0, waiting for the first sample of a frame
// SHIFT | 1..DATA_W-1 bits of the current frame captured
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              serial_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] parallel_out,
  output logic              frame_err,
  output logic              overrun
`ifdef S2P_STATS_EN
  ,
  output logic [STAT_W-1:0] frame_cnt,
  output logic [STAT_W-1:0] err_cnt
`endif
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  state_e                     state_q, state_d;
  logic [CW-1:0]              bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]          shift_q, shift_d;
  logic                       frame_err_q, frame_err_d;
  logic                       overrun_q, overrun_d;
  logic [DATA_W-1:0]          shifted;
  logic                       frame_done;
  logic                       pop;
  logic                       fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // New bits enter at the top so the first sample ends up in bit 0.
  assign shifted = {serial_in, shift_q[DATA_W-1:1]};

  // State register, shift register and registered error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next state: every valid cycle samples; completion returns to IDLE so a
  // following valid cycle starts the next frame without a gap.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          state_d   = SHIFT;
          bit_cnt_d = CW'(1);
          shift_d   = shifted;
        end
      end
      SHIFT: begin
        if (!valid_in) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (bit_cnt_q == LAST_BIT) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          shift_d   = shifted;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shift_d   = shifted;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Outputs: frame push, truncation and overrun detection.
  always_comb begin
    frame_done  = (state_q == SHIFT) && valid_in && (bit_cnt_q == LAST_BIT);
    frame_err_d = (state_q == SHIFT) && !valid_in;
    pop         = out_ready && !fifo_empty;
    overrun_d   = frame_done && fifo_full && !pop;
  end

  s2p_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (frame_done),
    .din   (shifted),
    .pop   (pop),
    .dout  (parallel_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

`ifdef S2P_STATS_EN
  logic [STAT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [STAT_W-1:0] err_cnt_q, err_cnt_d;

  // Statistics: accepted frames and error events (a same-edge pair adds two).
  always_comb begin
    frame_cnt_d = sat_add(frame_cnt_q, {1'b0, frame_done && !overrun_d});
    err_cnt_d   = sat_add(err_cnt_q, {1'b0, frame_err_d} + {1'b0, overrun_d});
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel (default build, stats disabled).
module tb_serial_to_parallel;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          valid_in  = 1'b0;
  logic          serial_in = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] parallel_out;
  logic          frame_err;
  logic          overrun;

  always #5 clk = ~clk;

  serial_to_parallel #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .serial_in    (serial_in),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .parallel_out (parallel_out),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  int            checks = 0;
  int            errors = 0;
  int            fe_seen = 0;
  int            ov_seen = 0;
  bit            bits[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_words[$];
  logic          exp_fe = 1'b0;
  logic          exp_ov = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits collected in a list, a frame is the first DW of them,
  // the buffer is a bounded queue. Advanced once per rising edge.
  task automatic model_step();
    logic [DW-1:0] w;
    bit            push;
    bit            do_pop;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    w      = '0;
    if (!rst_n) begin
      bits.delete();
      mq.delete();
      return;
    end
    do_pop = out_ready && (mq.size() > 0);
    push   = 1'b0;
    if (valid_in) begin
      bits.push_back(serial_in);
      if (bits.size() == DW) begin
        foreach (bits[i]) w[i] = bits[i];
        bits.delete();
        push = 1'b1;
      end
    end else if (bits.size() != 0) begin
      exp_fe = 1'b1;
      bits.delete();
    end
    if (push && mq.size() == DEPTH && !do_pop) begin
      exp_ov = 1'b1;
      push   = 1'b0;
    end
    if (do_pop) void'(mq.pop_front());
    if (push) mq.push_back(w);
  endtask

  // Monitor: after each edge compare against the model; before the next edge
  // record every word the consumer actually takes.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
      chk("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) chk("parallel_out", parallel_out, mq[0]);
      chk("frame_err", frame_err, exp_fe);
      chk("overrun", overrun, exp_ov);
      if (frame_err) fe_seen++;
      if (overrun) ov_seen++;
      @(negedge clk);
      #2;
      if (out_valid && out_ready) got_q.push_back(parallel_out);
    end
  end

  task automatic drive(input logic v, input logic s, input logic r);
    @(negedge clk);
    valid_in  = v;
    serial_in = s;
    out_ready = r;
  endtask

  task automatic send(input logic [DW-1:0] w, input logic r);
    for (int i = 0; i < DW; i++) drive(1'b1, w[i], r);
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) drive(1'b0, 1'b0, r);
  endtask

  task automatic start_scn();
    got_q.delete();
    exp_words.delete();
    fe_seen = 0;
    ov_seen = 0;
  endtask

  task automatic check_scn(input string name, input int fe_exp, input int ov_exp);
    chk({name, "_words"}, got_q.size(), exp_words.size());
    for (int i = 0; i < exp_words.size() && i < got_q.size(); i++)
      chk({name, "_word"}, got_q[i], exp_words[i]);
    chk({name, "_frame_err_pulses"}, fe_seen, fe_exp);
    chk({name, "_overrun_pulses"}, ov_seen, ov_exp);
  endtask

  initial begin
    logic [DW-1:0] w5;
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_parallel_out", parallel_out, '0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single frame 0xA5
    start_scn();
    idle(1, 1'b1);
    send(8'hA5, 1'b1);
    idle(3, 1'b1);
    exp_words.push_back(8'hA5);
    check_scn("single", 0, 0);

    // Back-to-back frames, valid held 16 cycles
    start_scn();
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b1);
    idle(3, 1'b1);
    exp_words.push_back(8'h3C);
    exp_words.push_back(8'hC3);
    check_scn("b2b", 0, 0);

    // Truncated after 5 bits, then a full frame
    start_scn();
    w5 = 8'h1B;
    for (int i = 0; i < 5; i++) drive(1'b1, w5[i], 1'b1);
    idle(1, 1'b1);
    send(8'h81, 1'b1);
    idle(3, 1'b1);
    exp_words.push_back(8'h81);
    check_scn("trunc", 1, 0);

    // Overrun: six frames with no consumer
    start_scn();
    for (int f = 1; f <= 6; f++) send(DW'(f), 1'b0);
    idle(2, 1'b0);
    idle(6, 1'b1);
    for (int f = 1; f <= 4; f++) exp_words.push_back(DW'(f));
    check_scn("overrun", 0, 2);

    // Full buffer, pop on the completing edge of 0x77
    start_scn();
    for (int f = 0; f < 4; f++) send(DW'(8'h11 + f), 1'b0);
    w5 = 8'h77;
    for (int i = 0; i < DW - 1; i++) drive(1'b1, w5[i], 1'b0);
    drive(1'b1, w5[DW-1], 1'b1);
    idle(6, 1'b1);
    for (int f = 0; f < 4; f++) exp_words.push_back(DW'(8'h11 + f));
    exp_words.push_back(8'h77);
    check_scn("full_pop", 0, 0);

    // Reset mid-frame with two frames buffered
    start_scn();
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    w5 = 8'h0F;
    for (int i = 0; i < 4; i++) drive(1'b1, w5[i], 1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_parallel_out", parallel_out, '0);
    chk("midrst_frame_err", frame_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h5A, 1'b1);
    idle(3, 1'b1);
    exp_words.push_back(8'h5A);
    check_scn("midrst", 0, 0);

    // Random traffic against the model
    start_scn();
    repeat (400) drive(($urandom % 10) != 0, 1'($urandom), 1'($urandom));
    idle(DEPTH + 4, 1'b1);
    chk("rand_drained", out_valid, 1'b0);

    idle(2, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 Parameter DATA_W, default 8: bits per frame.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two >= 2: output buffer depth in frames.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 valid_in  input  1  high while a frame's bits are on serial_in.
REQ-006 serial_in  input  1  serial data bit, LSB first.
REQ-007 out_ready  input  1  consumer accepts parallel_out this cycle.
REQ-008 out_valid  output  1  parallel_out holds an unconsumed frame.
REQ-009 parallel_out  output  DATA_W  oldest buffered frame.
REQ-010 frame_err  output  1  one-cycle pulse: frame truncated.
REQ-011 overrun  output  1  one-cycle pulse: completed frame dropped because the buffer was full.

Function
REQ-012 The block SHALL sample serial_in on every rising edge where valid_in=1; cycles with valid_in=0 SHALL sample nothing.
REQ-013 The first sampled bit SHALL be bit 0 of the frame, and bit k SHALL be the k-th sample (LSB first).
REQ-014 The state machine SHALL have two states:
- IDLE: bit counter 0.
- SHIFT: 1..DATA_W-1 bits captured.
REQ-015 Transitions:
- IDLE->SHIFT on a sample.
- SHIFT->IDLE on the DATA_W-th sample (frame complete) or when valid_in=0 (truncation).
REQ-016 A frame is complete on the edge that samples bit DATA_W-1. That edge SHALL push the assembled word into the FIFO.
REQ-017 If valid_in stays high after a complete frame, the next sample SHALL be bit 0 of a new frame, with no gap cycle (back-to-back frames).
REQ-018 valid_in=0 in SHIFT SHALL discard the partial frame, return to IDLE and pulse frame_err for exactly one cycle. Nothing is pushed.
REQ-019 Latency: out_valid SHALL rise in the cycle right after the completing edge when the FIFO was empty. parallel_out SHALL equal the completed word in that cycle.
REQ-020 A frame SHALL be popped on any edge with out_valid=1 and out_ready=1. parallel_out and out_valid SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 Push into a full FIFO with no simultaneous pop SHALL drop the new word, pulse overrun for one cycle and leave FIFO contents unchanged.
REQ-022 Push and pop on the same edge when full SHALL both take effect, with no overrun. Occupancy is unchanged.
REQ-023 Push and pop on the same edge when holding one entry SHALL leave out_valid=1 and present the new word next cycle.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Occupancy SHALL be tracked with log2(FIFO_DEPTH)+1 bits so full and empty are distinguished.
REQ-025 frame_err and overrun SHALL be registered. If a truncation and an overrun fall on the same edge, both SHALL pulse.

Reset
REQ-026 rst_n low SHALL immediately force:
- state IDLE, bit counter 0;
- FIFO empty;
- out_valid=0, parallel_out=0, frame_err=0, overrun=0.
REQ-027 Reset mid-frame SHALL discard the partial frame without a frame_err pulse. Reset SHALL discard all buffered frames.
REQ-028 The first edge after rst_n rises SHALL sample a bit if valid_in=1, treating it as bit 0.

Configuration
REQ-029 Macro S2P_STATS_EN defined SHALL add two outputs:
- frame_cnt[15:0]: counts pushed frames.
- err_cnt[15:0]: counts frame_err and overrun events (a same-edge pair counts 2).
Both SHALL saturate at 16'hFFFF and reset to 0.
REQ-030 Macro S2P_STATS_EN undefined SHALL remove both ports and their logic. All other behaviour SHALL be identical.

Structure
REQ-031 Package s2p_pkg SHALL hold:
- the state enum (IDLE, SHIFT);
- DATA_W_DEF=8 and FIFO_DEPTH_DEF=4;
- STAT_W=16.
REQ-032 The FIFO SHALL be the sub-module s2p_fifo, parameterised by width and depth, with push/pop/full/empty/count. The shift/framing FSM SHALL stay in serial_to_parallel.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Single frame 0xA5 sent LSB first (1,0,1,0,0,1,0,1), out_ready=1 -> out_valid for 1 cycle starting the cycle after the 8th bit; parallel_out=0xA5; no error pulses.
- Back-to-back 0x3C, 0xC3 with valid_in held 16 cycles and out_ready=1 -> two pops, 0x3C then 0xC3; no gap; no frame_err.
- valid_in drops after 5 bits, then full frame 0x81 -> one frame_err pulse; only 0x81 delivered.
- out_ready=0 and 6 frames 0x01..0x06 -> FIFO holds 0x01..0x04; overrun pulses for 0x05 and 0x06; draining yields 0x01..0x04 in order.
- FIFO full, out_ready=1 on the completing edge of frame 0x77 -> no overrun; 0x77 delivered after the existing entries.
- rst_n asserted after 4 bits of a frame with 2 frames buffered -> out_valid=0 immediately; no frame_err; next full frame 0x5A delivered correctly.
